vec_dispatch_unit: RTL and testbench
====================================

# vec_dispatch_unit

Scalar-side dispatch buffer that sits directly upstream of the vector processor's instruction/data queue. It accepts vector instructions with their rs1/rs2 operands from the scalar pipeline into a small FIFO. It issues them one at a time over the inst_valid/vec_pro_ready handshake and holds each entry until the vector processor acknowledges completion with vec_pro_ack. On completion of a vsetvl-class instruction it captures csr_out for scalar write-back, and it flags completions that never arrive.

## Interface
- XLEN, 32, data/instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- ACK_TIMEOUT, 255, max cycles in WAIT_ACK before timeout; ≥1

- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- enq_valid  in  1  scalar pipeline offers an instruction
- enq_ready  out  1  count < DEPTH
- enq_instruction / enq_rs1_data / enq_rs2_data  in  XLEN each  payload
- inst_valid  out  1  to vector processor, high in ISSUE
- instruction / rs1_data / rs2_data  out  XLEN each  FIFO head payload, always driven from head
- vec_pro_ready  in  1  vector processor accepts
- vec_pro_ack  in  1  vector processor completed current instruction
- scalar_pro_ready  out  1  high in WAIT_ACK
- csr_out  in  XLEN  CSR read data from vector processor
- rd_valid  out  1  one-cycle pulse: vsetvl completed
- rd_data  out  XLEN  captured csr_out, held until next capture
- err_timeout  out  1  sticky, set on ack timeout
- busy  out  1  state != IDLE or count != 0

## Operation
- FIFO: write ptr, read ptr ($clog2(DEPTH) bits, natural wrap), count ($clog2(DEPTH+1) bits). enq_fire = enq_valid & enq_ready. pop = WAIT_ACK & (vec_pro_ack | timeout). Simultaneous enq_fire and pop: count unchanged, both ptrs advance.
- enq_ready does not depend on pop; a full FIFO stays not-ready during the popping cycle.
- FSM states IDLE, ISSUE, WAIT_ACK.
  - IDLE: count != 0 → ISSUE.
  - ISSUE: vec_pro_ready → WAIT_ACK; otherwise stay; payload stable.
  - WAIT_ACK: timeout counter increments each cycle. On vec_pro_ack: pop; if (count − 1 + enq_fire) > 0 → ISSUE, else → IDLE. If the counter reaches ACK_TIMEOUT without ack: set err_timeout, pop, same next-state rule. Counter clears on entering WAIT_ACK.
- vsetvl-class = head opcode[6:0]==7'b1010111 and funct3[14:12]==3'b111. On ack of such an entry: rd_data <= csr_out, rd_valid <= 1 the next cycle. No capture on timeout.
- vec_pro_ack in IDLE/ISSUE: ignored. vec_pro_ready outside ISSUE: ignored.
- err_timeout clears only on reset.

## Timing
- Reset: state IDLE, ptrs/count 0, inst_valid 0, scalar_pro_ready 0, rd_valid 0, rd_data 0, err_timeout 0, busy 0, enq_ready 1. The FIFO array is not reset; the payload outputs are don't-care while inst_valid is 0.
- Enqueue accepted at edge N into an empty, idle unit: inst_valid is high from edge N+1.
- Handshake at edge M (ISSUE & vec_pro_ready): inst_valid low and scalar_pro_ready high from edge M.
- Ack at edge K: rd_valid and rd_data valid from K for one cycle. Next entry's inst_valid from K (back-to-back, no bubble).
- inst_valid, scalar_pro_ready and busy are decoded from registered state/count only; there is no combinational path from inputs.
- Reset mid-operation (any state): everything returns to the reset values at the next edge; in-flight and queued entries are discarded.

## Test plan
- Single instruction: enqueue add (0x02208057), rs1=5 → inst_valid at N+1; ready held low 3 cycles → payload stable; ready → WAIT_ACK; ack → busy 0, rd_valid stays 0.
- vsetvli 0x0D0072D7, csr_out=0x10 at ack → rd_valid pulse for 1 cycle, rd_data=0x10 retained afterwards.
- Fill: 5 enqueues with ready low → enq_ready drops after the 4th. The 5th is held until the first pop; order is preserved across pointer wrap (8 instructions total).
- Back-to-back: 3 queued with immediate ready/ack → inst_valid reasserts on the ack edge with no bubble. Simultaneous enq+pop at count=1 → count stays 1.
- Timeout: ACK_TIMEOUT=4, no ack → err_timeout set after 4 WAIT_ACK cycles, entry popped, next entry issued; a later ack does not clear the flag.
- Reset asserted in WAIT_ACK with 2 queued → next cycle all outputs are at reset values and enq_ready=1.

Source files
------------

// File: rtl/vec_dispatch_unit.sv
// Dispatch buffer between the scalar pipeline and the vector processor.
// Queues instructions with operands, issues them one at a time, holds each
// entry until completion is acknowledged, captures vsetvl results and flags
// completions that never arrive.
//
//  state      | meaning
//  -----------+--------------------------------------------------------
//  S_IDLE     | nothing offered; leaves as soon as the FIFO is non-empty
//  S_ISSUE    | head entry offered on inst_valid, waiting for vec_pro_ready
//  S_WAIT_ACK | head accepted, waiting for vec_pro_ack or ack timeout
module vec_dispatch_unit #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enq_valid,
  output logic            enq_ready,
  input  logic [XLEN-1:0] enq_instruction,
  input  logic [XLEN-1:0] enq_rs1_data,
  input  logic [XLEN-1:0] enq_rs2_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            vec_pro_ready,
  input  logic            vec_pro_ack,
  output logic            scalar_pro_ready,
  input  logic [XLEN-1:0] csr_out,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_data,
  output logic            err_timeout,
  output logic            busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] rs1_mem  [DEPTH];
  logic [XLEN-1:0] rs2_mem  [DEPTH];

  logic enq_fire, ack_hit, timeout, pop, is_vsetvl;

  assign enq_ready        = (count != CW'(DEPTH));
  assign enq_fire         = enq_valid & enq_ready;
  assign ack_hit          = (state == S_WAIT_ACK) & vec_pro_ack;
  // Ack takes priority when it lands on the terminal-count cycle.
  assign timeout          = (state == S_WAIT_ACK) & ~vec_pro_ack & (tmo_cnt == '0);
  assign pop              = ack_hit | timeout;

  assign instruction      = inst_mem[rd_ptr];
  assign rs1_data         = rs1_mem[rd_ptr];
  assign rs2_data         = rs2_mem[rd_ptr];
  assign is_vsetvl        = (instruction[6:0] == 7'b1010111) && (instruction[14:12] == 3'b111);

  assign inst_valid       = (state == S_ISSUE);
  assign scalar_pro_ready = (state == S_WAIT_ACK);
  assign busy             = (state != S_IDLE) || (count != '0);

  // Occupancy after this edge's enqueue and pop.
  always_comb begin
    count_nxt = count;
    if (enq_fire && !pop)      count_nxt = count + CW'(1);
    else if (pop && !enq_fire) count_nxt = count - CW'(1);
  end

  // Payload storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      inst_mem[wr_ptr] <= enq_instruction;
      rs1_mem[wr_ptr]  <= enq_rs1_data;
      rs2_mem[wr_ptr]  <= enq_rs2_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; after a pop, go straight back to ISSUE if anything remains.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (count != '0) state_nxt = S_ISSUE;
      S_ISSUE:    if (vec_pro_ready) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (pop) state_nxt = (count_nxt != '0) ? S_ISSUE : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Ack timer: loaded on entry to WAIT_ACK, expires when it reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if ((state == S_ISSUE) && vec_pro_ready) begin
      tmo_cnt <= TW'(ACK_TIMEOUT - 1);
    end else if ((state == S_WAIT_ACK) && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - TW'(1);
    end
  end

  // vsetvl result capture and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      rd_valid <= ack_hit & is_vsetvl;
      if (ack_hit && is_vsetvl) rd_data <= csr_out;
      if (timeout) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vec_dispatch_unit.sv
// Self-checking bench for vec_dispatch_unit: directed scenarios plus a random
// phase, every cycle compared against a queue-based behavioural model.
module tb_vec_dispatch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_instruction, enq_rs1_data, enq_rs2_data;
  logic            inst_valid;
  logic [XLEN-1:0] instruction, rs1_data, rs2_data;
  logic            vec_pro_ready, vec_pro_ack;
  logic            scalar_pro_ready;
  logic [XLEN-1:0] csr_out;
  logic            rd_valid;
  logic [XLEN-1:0] rd_data;
  logic            err_timeout;
  logic            busy;

  vec_dispatch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_instruction(enq_instruction), .enq_rs1_data(enq_rs1_data), .enq_rs2_data(enq_rs2_data),
    .inst_valid(inst_valid), .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .vec_pro_ready(vec_pro_ready), .vec_pro_ack(vec_pro_ack),
    .scalar_pro_ready(scalar_pro_ready), .csr_out(csr_out),
    .rd_valid(rd_valid), .rd_data(rd_data), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] r1;
    logic [31:0] r2;
  } ent_t;

  ent_t mq[$];    // model: entries held by the unit, head first
  ent_t pend[$];  // stimulus: entries the scalar side still wants to send

  // model phase: 0 nothing offered, 1 head offered, 2 head accepted awaiting ack
  int          m_phase;
  int          m_wait;
  bit          m_err, m_rdv;
  logic [31:0] m_rdd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("enq_ready", 32'(enq_ready), 32'(mq.size() < DEPTH));
    chk("inst_valid", 32'(inst_valid), 32'(m_phase == 1));
    chk("scalar_pro_ready", 32'(scalar_pro_ready), 32'(m_phase == 2));
    chk("busy", 32'(busy), 32'((m_phase != 0) || (mq.size() != 0)));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    chk("rd_data", rd_data, m_rdd);
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    if (m_phase == 1) begin
      chk("instruction", instruction, mq[0].ins);
      chk("rs1_data", rs1_data, mq[0].r1);
      chk("rs2_data", rs2_data, mq[0].r2);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enq_valid = 1'b0; vec_pro_ready = 1'b0; vec_pro_ack = 1'b0;
    @(posedge clk);
    mq.delete(); pend.delete();
    m_phase = 0; m_wait = 0; m_err = 0; m_rdv = 0; m_rdd = '0;
    #1 check_outputs();
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic cyc(input bit rdy, input bit ack, input logic [31:0] csr);
    bit fire, pop, ackd;
    @(negedge clk);
    reset         = 1'b0;
    enq_valid     = (pend.size() > 0);
    if (enq_valid) begin
      enq_instruction = pend[0].ins; enq_rs1_data = pend[0].r1; enq_rs2_data = pend[0].r2;
    end else begin
      enq_instruction = $urandom; enq_rs1_data = $urandom; enq_rs2_data = $urandom;
    end
    vec_pro_ready = rdy;
    vec_pro_ack   = ack;
    csr_out       = csr;
    @(posedge clk);
    fire = enq_valid && (mq.size() < DEPTH);
    pop = 0; ackd = 0;
    case (m_phase)
      0: if (mq.size() > 0) m_phase = 1;
      1: if (rdy) begin m_phase = 2; m_wait = 0; end
      default: begin
        m_wait++;
        if (ack) begin ackd = 1; pop = 1; end
        else if (m_wait == TMO) begin m_err = 1; pop = 1; end
      end
    endcase
    m_rdv = 0;
    if (ackd && mq[0].ins[6:0] == 7'h57 && mq[0].ins[14:12] == 3'b111) begin
      m_rdv = 1; m_rdd = csr;
    end
    if (pop) void'(mq.pop_front());
    if (fire) mq.push_back(pend.pop_front());
    if (pop) m_phase = (mq.size() > 0) ? 1 : 0;
    #1 check_outputs();
  endtask

  task automatic run(input int n, input int p_rdy, input int p_ack);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(99) < p_rdy, $urandom_range(99) < p_ack, $urandom);
  endtask

  task automatic push(input logic [31:0] ins);
    ent_t e;
    e.ins = ins; e.r1 = $urandom; e.r2 = $urandom;
    pend.push_back(e);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(2))
      0: r = 32'h0220_8057;
      1: begin r[6:0] = 7'h57; r[14:12] = 3'b111; end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    ent_t e;
    reset = 1'b1; enq_valid = 1'b0; vec_pro_ready = 1'b0; vec_pro_ack = 1'b0;
    enq_instruction = '0; enq_rs1_data = '0; enq_rs2_data = '0; csr_out = '0;
    do_reset();
    run(2, 0, 0);

    // single add: offered, held 3 cycles, accepted, acked without capture
    e.ins = 32'h0220_8057; e.r1 = 32'd5; e.r2 = $urandom;
    pend.push_back(e);
    run(4, 0, 0);
    cyc(1, 0, $urandom);
    cyc(0, 0, $urandom);
    cyc(0, 1, 32'hdead_beef);
    run(2, 0, 1);

    // vsetvli with capture, value retained afterwards
    push(32'h0D00_72D7);
    run(2, 0, 0);
    cyc(1, 0, $urandom);
    cyc(0, 1, 32'h10);
    run(3, 0, 0);
    chk("rd_data_held", rd_data, 32'h10);

    // fill past depth, then drain in order across the pointer wrap
    for (int i = 0; i < 8; i++) push(rand_ins());
    run(6, 0, 0);
    chk("full_not_ready", 32'(enq_ready), 32'd0);
    run(40, 100, 100);

    // back-to-back issue of three entries
    for (int i = 0; i < 3; i++) push(rand_ins());
    run(12, 100, 100);

    // enqueue on the same edge as a pop at count 1
    push(rand_ins());
    run(3, 100, 0);
    push(rand_ins());
    cyc(0, 1, $urandom);
    run(6, 100, 100);

    // ack timeout on two entries, then a later ack leaves the flag set
    push(rand_ins()); push(rand_ins());
    run(14, 100, 0);
    chk("err_sticky", 32'(err_timeout), 32'd1);
    push(32'h0D00_72D7);
    run(6, 100, 100);

    // reset while waiting for ack with more entries queued
    for (int i = 0; i < 3; i++) push(rand_ins());
    run(3, 100, 0);
    do_reset();
    chk("reset_enq_ready", 32'(enq_ready), 32'd1);

    // random traffic, including occasional timeouts
    for (int i = 0; i < 400; i++) begin
      if (pend.size() < 3 && $urandom_range(99) < 50) push(rand_ins());
      cyc($urandom_range(99) < 60, $urandom_range(99) < 45, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
